// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and load/store requesters.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
    input  logic last_gnt,
    output logic winner
);

    // On a tie the requester that was not granted last wins; a constant
    // last_gnt of GNT_INST therefore yields fixed data-over-inst priority.
    always_comb begin
        winner = GNT_INST;
        if (inst_req && data_req) begin
            winner = (last_gnt == GNT_DATA) ? GNT_INST : GNT_DATA;
        end else if (data_req) begin
            winner = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one SRAM-like port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed data-over-inst priority.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [STRB_W-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state, state_nxt;
    logic   gnt, gnt_nxt;
    logic   load_gnt;
    logic   winner;
    logic   last_gnt;
    logic   any_req;

    assign any_req = inst_req | data_req;

    mem_arb_pick u_pick (
        .inst_req (inst_req),
        .data_req (data_req),
        .last_gnt (last_gnt),
        .winner   (winner)
    );

`ifdef MEM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= GNT_INST;
        end else if (load_gnt) begin
            last_q <= winner;
        end
    end

    assign last_gnt = last_q;
`else
    assign last_gnt = GNT_INST;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            gnt   <= GNT_INST;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_gnt     = 1'b0;
        mem_req      = 1'b0;
        mem_wstrb    = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        case (state)
            S_IDLE: begin
                if (any_req) begin
                    load_gnt  = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            // Request fields follow the granted requester's live inputs.
            S_ADDR: begin
                mem_req   = 1'b1;
                mem_wstrb = (gnt == GNT_DATA) ? data_wstrb : inst_wstrb;
                mem_addr  = (gnt == GNT_DATA) ? data_addr  : inst_addr;
                mem_wdata = (gnt == GNT_DATA) ? data_wdata : inst_wdata;
                if (mem_addr_ok) begin
                    inst_addr_ok = (gnt == GNT_INST);
                    data_addr_ok = (gnt == GNT_DATA);
                    state_nxt    = S_DATA;
                end
            end
            // A pending request is granted in the response cycle to avoid an idle bubble.
            S_DATA: begin
                if (mem_data_ok) begin
                    inst_data_ok = (gnt == GNT_INST);
                    data_data_ok = (gnt == GNT_DATA);
                    if (any_req) begin
                        load_gnt  = 1'b1;
                        state_nxt = S_ADDR;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign gnt_nxt = load_gnt ? winner : gnt;
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model, directed scenarios, random traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [3:0]  inst_wstrb = '0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_wdata = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] rdata;
    logic        mem_req;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .rdata        (rdata),
        .mem_req      (mem_req),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    int checks = 0;
    int failures = 0;

    // Transaction model: who owns the SRAM port (-1 none, 0 inst, 1 data),
    // whether its request has been accepted, and who won the last grant.
    int owner = -1;
    bit accepted = 1'b0;
    int last = 0;

    logic        e_req, e_iaok, e_daok, e_idok, e_ddok;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
            return (last == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        return dr ? 1 : 0;
    endfunction

    task automatic eval();
        #2;
        if (reset) begin
            owner = -1;
            accepted = 1'b0;
            last = 0;
        end
        e_req   = (owner >= 0) && !accepted;
        e_strb  = !e_req ? 4'h0  : (owner == 1 ? data_wstrb : inst_wstrb);
        e_addr  = !e_req ? 32'h0 : (owner == 1 ? data_addr  : inst_addr);
        e_wdata = !e_req ? 32'h0 : (owner == 1 ? data_wdata : inst_wdata);
        e_iaok  = (owner == 0) && !accepted && mem_addr_ok;
        e_daok  = (owner == 1) && !accepted && mem_addr_ok;
        e_idok  = (owner == 0) && accepted && mem_data_ok;
        e_ddok  = (owner == 1) && accepted && mem_data_ok;
        chk("mem_req", mem_req, e_req);
        chk("mem_wstrb", mem_wstrb, e_strb);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("inst_addr_ok", inst_addr_ok, e_iaok);
        chk("data_addr_ok", data_addr_ok, e_daok);
        chk("inst_data_ok", inst_data_ok, e_idok);
        chk("data_data_ok", data_data_ok, e_ddok);
        chk("rdata", rdata, mem_rdata);
    endtask

    task automatic tick();
        int n_owner;
        bit n_acc;
        int n_last;
        n_owner = owner;
        n_acc = accepted;
        n_last = last;
        if (!reset) begin
            if (owner < 0 || (accepted && mem_data_ok)) begin
                n_acc = 1'b0;
                if (inst_req || data_req) begin
                    n_owner = pick(inst_req, data_req);
                    n_last = n_owner;
                end else begin
                    n_owner = -1;
                end
            end else if (!accepted && mem_addr_ok) begin
                n_acc = 1'b1;
            end
        end
        @(posedge clk);
        owner = n_owner;
        accepted = n_acc;
        last = n_last;
        #1;
        if (e_iaok) inst_req = 1'b0;
        if (e_daok) data_req = 1'b0;
    endtask

    task automatic mem_quiet();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            mem_addr_ok = 1'b1;
            mem_data_ok = 1'b1;
            eval();
            tick();
        end
        mem_quiet();
    endtask

    initial begin
        // Reset held with a load pending and SRAM handshakes high.
        data_req = 1'b1; data_addr = 32'h1000; data_wstrb = 4'h0;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        @(posedge clk); #1;
        eval();
        chk("rst_mem_req", mem_req, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_data_addr_ok", data_addr_ok, 32'h0);
        chk("rst_data_data_ok", data_data_ok, 32'h0);
        tick();

        // Single load.
        reset = 1'b0; mem_quiet();
        eval();
        chk("load_idle_mem_req", mem_req, 32'h0);
        tick();
        mem_addr_ok = 1'b1;
        eval();
        chk("load_mem_req", mem_req, 32'h1);
        chk("load_mem_addr", mem_addr, 32'h1000);
        chk("load_data_addr_ok", data_addr_ok, 32'h1);
        chk("load_inst_addr_ok", inst_addr_ok, 32'h0);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEADBEEF;
        eval();
        chk("load_data_data_ok", data_data_ok, 32'h1);
        chk("load_rdata", rdata, 32'hDEADBEEF);
        chk("load_inst_data_ok", inst_data_ok, 32'h0);
        tick();
        mem_quiet();
        eval();
        chk("load_data_ok_once", data_data_ok, 32'h0);
        tick();

        // Store fields presented in ADDR.
        data_req = 1'b1; data_wstrb = 4'hF; data_wdata = 32'h12345678; data_addr = 32'h2004;
        eval(); tick();
        mem_addr_ok = 1'b1;
        eval();
        chk("store_mem_wstrb", mem_wstrb, 32'hF);
        chk("store_mem_wdata", mem_wdata, 32'h12345678);
        chk("store_mem_addr", mem_addr, 32'h2004);
        tick();
        drain(2);

        // Address stall with a spurious response, then accept with both handshakes high.
        data_req = 1'b1; data_wstrb = 4'h0; data_addr = 32'h5000;
        eval(); tick();
        for (int i = 0; i < 5; i++) begin
            mem_data_ok = (i == 0);
            eval();
            chk("stall_mem_req", mem_req, 32'h1);
            chk("stall_mem_addr", mem_addr, 32'h5000);
            chk("stall_data_addr_ok", data_addr_ok, 32'h0);
            chk("stall_data_data_ok", data_data_ok, 32'h0);
            tick();
        end
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        eval();
        chk("stall_accept_addr_ok", data_addr_ok, 32'h1);
        chk("stall_accept_no_data_ok", data_data_ok, 32'h0);
        tick();

        // Reset in the response phase discards the transaction.
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; reset = 1'b1;
        eval();
        chk("rstdata_data_data_ok", data_data_ok, 32'h0);
        tick();
        reset = 1'b0;
        eval();
        chk("rstdata_late_data_ok", data_data_ok, 32'h0);
        chk("rstdata_mem_req", mem_req, 32'h0);
        tick();
        mem_quiet();

        // Collision, with data re-requesting during its own response.
        inst_req = 1'b1; inst_addr = 32'h4000; inst_wstrb = 4'h0;
        data_req = 1'b1; data_addr = 32'h3000; data_wstrb = 4'h0;
        eval(); tick();
        mem_addr_ok = 1'b1;
        eval();
        chk("coll_first_addr", mem_addr, 32'h3000);
        chk("coll_first_data_aok", data_addr_ok, 32'h1);
        chk("coll_first_inst_aok", inst_addr_ok, 32'h0);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        data_req = 1'b1; data_addr = 32'h3100;
        eval();
        chk("coll_data_data_ok", data_data_ok, 32'h1);
        tick();
        mem_quiet();
        eval();
`ifdef MEM_ARB_RR_EN
        chk("coll_second_addr", mem_addr, 32'h4000);
`else
        chk("coll_second_addr", mem_addr, 32'h3100);
`endif
        tick();
        drain(6);

        // Random traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 3000; c++) begin
            if (!inst_req && $urandom_range(0, 99) < 40) begin
                inst_req = 1'b1;
                inst_addr = $urandom;
                inst_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(0, 99) < 40) begin
                data_req = 1'b1;
                data_addr = $urandom;
                data_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                data_wdata = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 99) < 50);
            mem_data_ok = ($urandom_range(0, 99) < 50);
            mem_rdata = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            eval();
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port inst_req  in  1  fetch request, held until inst_addr_ok.
REQ-004 SHALL have port inst_wstrb  in  4  byte write strobes; 0 = read.
REQ-005 SHALL have port inst_addr  in  32  fetch byte address.
REQ-006 SHALL have port inst_wdata  in  32  fetch write data.
REQ-007 SHALL have port inst_addr_ok  out  1  fetch request accepted, 1-cycle pulse.
REQ-008 SHALL have port inst_data_ok  out  1  fetch response valid, 1-cycle pulse.
REQ-009 SHALL have port data_req  in  1  load/store request, held until data_addr_ok.
REQ-010 SHALL have port data_wstrb  in  4  byte write strobes; 0 = load.
REQ-011 SHALL have port data_addr  in  32  load/store byte address.
REQ-012 SHALL have port data_wdata  in  32  store data.
REQ-013 SHALL have port data_addr_ok  out  1  load/store accepted, 1-cycle pulse.
REQ-014 SHALL have port data_data_ok  out  1  load/store response valid, 1-cycle pulse.
REQ-015 SHALL have port rdata  out  32  read data, shared; valid with either data_ok.
REQ-016 SHALL have port mem_req  out  1  request to the shared SRAM port.
REQ-017 SHALL have port mem_wstrb  out  4  strobes of granted requester.
REQ-018 SHALL have port mem_addr  out  32  address of granted requester.
REQ-019 SHALL have port mem_wdata  out  32  write data of granted requester.
REQ-020 SHALL have port mem_addr_ok  in  1  SRAM accepted request.
REQ-021 SHALL have port mem_data_ok  in  1  SRAM response valid.
REQ-022 SHALL have port mem_rdata  in  32  SRAM read data.

Function
REQ-023 SHALL implement FSM IDLE/ADDR/DATA with one registered grant (INST or DATA) and at most one outstanding transaction.
REQ-024 SHALL, in IDLE with any req high, register the winner and enter ADDR next cycle; mem_req=1 only in ADDR.
REQ-025 SHALL drive mem_wstrb/addr/wdata combinationally from the granted requester's live inputs; zeros when not in ADDR.
REQ-026 SHALL, in ADDR with mem_addr_ok, pulse the granted <x>_addr_ok in that same cycle and enter DATA.
REQ-027 SHALL, in DATA with mem_data_ok, pulse the granted <x>_data_ok that cycle; rdata = mem_rdata passthrough.
REQ-028 SHALL, on DATA exit with any req pending, arbitrate that cycle and go directly to ADDR, else IDLE.
REQ-029 SHALL use fixed priority data over inst when both request in the same arbitration cycle.
REQ-030 SHALL never pulse the non-granted requester's addr_ok/data_ok; never both addr_ok outputs in one cycle.
REQ-031 SHALL ignore mem_addr_ok outside ADDR and mem_data_ok outside DATA, including a simultaneous mem_addr_ok+mem_data_ok in ADDR.
REQ-032 SHALL hold grant in ADDR even if the requester drops req (protocol violation; no re-arbitration).

Reset
REQ-033 SHALL, on reset asserted at any time, go to IDLE asynchronously; mem_req, all addr_ok/data_ok, mem_wstrb/addr/wdata = 0; in-flight transaction discarded.
REQ-034 SHALL resume arbitration on the first rising edge after reset deassertion.

Configuration
REQ-035 SHALL, with MEM_ARB_RR_EN defined, use round-robin: last-granted requester has lowest priority; reset value of last-grant = INST, so data wins first tie.
REQ-036 SHALL, without MEM_ARB_RR_EN, use fixed data-over-inst priority and contain no last-grant register.

Structure
REQ-037 SHALL place state enum, grant ID constants (GNT_INST, GNT_DATA) and width constants in package mem_arb_pkg.
REQ-038 SHALL put winner selection in sub-module mem_arb_pick (requests, last-grant in; winner out), purely combinational.

Verification
REQ-039 Single load: data_req=1, addr=0x1000, wstrb=0; mem_addr_ok at ADDR, mem_data_ok next cycle with 0xDEADBEEF -> data_addr_ok once, data_data_ok once, rdata=0xDEADBEEF, inst outputs 0.
REQ-040 Collision: inst_req and data_req both high in IDLE -> data granted first (mem_addr=data_addr); inst granted directly after data_data_ok; with MEM_ARB_RR_EN, second collision grants inst first.
REQ-041 Addr stall: mem_addr_ok low 5 cycles -> mem_req held 5+ cycles, fields stable, no addr_ok pulse until mem_addr_ok=1.
REQ-042 Store: data_wstrb=0xF, wdata=0x12345678, addr=0x2004 -> mem_wstrb=0xF, mem_wdata=0x12345678, mem_addr=0x2004 in ADDR.
REQ-043 Reset mid-DATA: assert reset after mem_addr_ok -> all outputs 0 immediately; later mem_data_ok produces no data_ok.
REQ-044 Spurious: mem_data_ok pulsed in IDLE and ADDR -> no data_ok output, FSM unaffected.
